if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
- Parametrised instruction-fetch stage. It replaces the fixed PC+4 fetch with a decoupled prefetch queue.
- It issues in-order requests to an instruction memory of arbitrary response latency and buffers up to DEPTH instructions with their PCs.
- It presents them to the IF/ID register through a valid/ready handshake. This gives stall support toward decode.
- Redirects from EX (taken branch/jump) flush the queue and squash in-flight responses.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, queue slots and maximum outstanding plus buffered fetches (power of two, at least 2).
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  instruction returned (in order, latency at least 1, no back-pressure)
- imem_rsp_data  in  XLEN  instruction word
- id_valid  out  1  head instruction available
- id_ready  in  1  decode accepts (low = stall)
- id_instr  out  XLEN  head instruction
- id_pc  out  XLEN  head PC
- id_pc_plus_4  out  XLEN  id_pc + 4
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0

Behaviour:
- Reset state:
  - Asynchronous, active-high.
  - fetch_pc = RESET_PC, all slots free, head = tail = 0, discard_cnt = 0.
  - imem_req_valid = 0, id_valid = 0; id_instr, id_pc, id_pc_plus_4 = 0.
- Slot states: FREE, WAIT (allocated, response pending), FULL (instruction held). Storage is a ring of DEPTH slots, each holding {pc, instr, state}.
- Issue:
  - imem_req_valid = !reset && !redirect_valid && (slots_used + discard_cnt < DEPTH).
  - imem_req_addr = fetch_pc.
  - On a handshake: allocate the tail slot as WAIT with pc = fetch_pc, advance tail, and set fetch_pc += 4 (mod 2^XLEN wrap).
- Response:
  - If discard_cnt > 0, drop the response and decrement discard_cnt.
  - Otherwise the oldest WAIT slot becomes FULL with instr = imem_rsp_data.
  - A response with no outstanding request is ignored and flagged by an assertion.
- Output:
  - id_valid = head slot is FULL; id_* are driven combinationally from the head slot.
  - When id_valid && id_ready, free the head slot and advance head.
  - The slot filled by a response becomes visible as FULL the cycle after the response (one registered stage).
- Latency and throughput:
  - With a 1-cycle memory and continuous readiness: request in cycle 0, response in cycle 1, id_valid in cycle 2.
  - Sustained throughput is 1 instruction/cycle.
- Stall:
  - With id_ready = 0 the head is held stable: id_instr and id_pc do not change while id_valid && !id_ready.
  - Issue continues until slots_used + discard_cnt = DEPTH, then stops. There is no overflow.
- Redirect, taking effect in the same cycle:
  - All slots are freed and head = tail.
  - discard_cnt += number of WAIT slots, minus 1 if a non-discarded response arrives that same cycle (that response is dropped).
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued in the redirect cycle. The first fetch from the new PC is issued in the next cycle.
  - Redirect has priority over a simultaneous pop, push and issue. A simultaneous id handshake is still considered consumed by decode.
- Back-to-back redirects: each redirect flushes and re-targets; discard_cnt accumulates correctly.
- Empty queue: id_valid = 0 and outputs hold the last values. There is no bubble insertion; IF/ID inserts the NOP.
- Counter widths: slots_used is $clog2(DEPTH+1) bits; discard_cnt is the same width and never exceeds DEPTH.
- Reset mid-operation: immediate return to the reset state. In-flight memory responses after reset deassertion are the memory's responsibility; imem must also be reset.

Decomposition:
- Shared package pipeline_pkg:
  - XLEN and the RESET_PC default.
  - NOP_INSTR = 32'h00000013.
  - slot_state_t enum (FREE/WAIT/FULL).
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_slot_ring (DEPTH-entry ring with alloc/fill/pop/flush) is natural. Issue, discard and PC logic stay in the top.

Test Plan:
- Reset release, 1-cycle memory, id_ready = 1: id_pc sequence 0x0, 0x4, 0x8, ... one per cycle from cycle 2; id_instr matches memory words (e.g. 0x00100093 at 0x0).
- id_ready = 0 for 10 cycles, DEPTH = 4: exactly 4 requests issued, then imem_req_valid = 0; head is 0x0 throughout. After release, PCs 0x0..0xC come out contiguous, then 0x10.
- 3-cycle memory latency, redirect to 0x103 with 2 requests in flight: the 2 stale responses are dropped; the next id_pc is 0x100; no stale instruction reaches decode.
- Redirect in the same cycle as a response and an id handshake: the response is dropped, the queue is empty next cycle, the next request address is the redirect target.
- imem_req_ready toggling at random, 2000 instructions, random stalls and redirects: a scoreboard confirms in-order PCs, each instruction matches its memory word, and no duplicates or losses occur.
- Assert reset mid-stream with 3 slots FULL: id_valid = 0 and imem_req_valid = 0 immediately; after release the first request address is RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types and constants.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_WAIT,
    SLOT_FULL
  } slot_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory, decode and redirect signals of the prefetch stage.
interface if_prefetch_queue_if;
  import pipeline_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus_4;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus_4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus_4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_slot_ring.sv
// Ring of fetch slots: allocate at tail, fill oldest waiting slot, pop at head, flush all.
module fetch_slot_ring
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_instr,
  input  logic            pop,
  input  logic            flush,
  output logic            head_full,
  output fetch_entry_t    head_entry,
  output logic [CW-1:0]   used_cnt,
  output logic [CW-1:0]   wait_cnt
);

  slot_state_t  state_q [DEPTH];
  fetch_entry_t entry_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, fill_q;

  // Responses return in order, so the oldest WAIT slot is tracked by its own pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      used_cnt <= '0;
      wait_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= SLOT_FREE;
        entry_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= SLOT_FREE;
      head_q   <= tail_q;
      fill_q   <= tail_q;
      used_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      if (alloc) begin
        state_q[tail_q]    <= SLOT_WAIT;
        entry_q[tail_q].pc <= alloc_pc;
        tail_q             <= tail_q + PW'(1);
      end
      if (fill) begin
        state_q[fill_q]       <= SLOT_FULL;
        entry_q[fill_q].instr <= fill_instr;
        fill_q                <= fill_q + PW'(1);
      end
      if (pop) begin
        state_q[head_q] <= SLOT_FREE;
        head_q          <= head_q + PW'(1);
      end
      used_cnt <= used_cnt + CW'(alloc) - CW'(pop);
      wait_cnt <= wait_cnt + CW'(alloc) - CW'(fill);
    end
  end

  assign head_full  = (state_q[head_q] == SLOT_FULL);
  assign head_entry = entry_q[head_q];

endmodule

// File: rtl/if_prefetch_queue.sv
// Decoupled instruction-fetch stage: in-order prefetch into a slot ring, valid/ready toward decode,
// redirect flush with squashing of responses still in flight.
module if_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic clk,
  input logic reset,
  if_prefetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q;
  logic [CW-1:0]   discard_q, used_cnt, wait_cnt;
  logic [CW:0]     in_use;
  logic            req_fire, rsp_drop, rsp_expected, fill, pop, head_full;
  fetch_entry_t    head_entry, last_entry_q;
  logic [XLEN-1:0] last_pc_plus_4_q;

  assign in_use       = {1'b0, used_cnt} + {1'b0, discard_q};
  assign req_fire     = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_expected = bus.imem_rsp_valid && ((discard_q != '0) || (wait_cnt != '0));
  assign rsp_drop     = bus.imem_rsp_valid && (discard_q != '0);
  assign fill         = bus.imem_rsp_valid && (discard_q == '0) && (wait_cnt != '0)
                        && !bus.redirect_valid;
  assign pop          = head_full && bus.id_ready && !bus.redirect_valid;

  assign bus.imem_req_valid = !reset && !bus.redirect_valid && (in_use < DEPTH_W);
  assign bus.imem_req_addr  = fetch_pc_q;

  fetch_slot_ring #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .reset      (reset),
    .alloc      (req_fire),
    .alloc_pc   (fetch_pc_q),
    .fill       (fill),
    .fill_instr (bus.imem_rsp_data),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .head_full  (head_full),
    .head_entry (head_entry),
    .used_cnt   (used_cnt),
    .wait_cnt   (wait_cnt)
  );

  // On redirect every still-pending response must be thrown away, less the one arriving now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q       <= RESET_PC;
      discard_q        <= '0;
      last_entry_q     <= '0;
      last_pc_plus_4_q <= '0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc_q <= bus.redirect_pc & ~XLEN'(3);
        discard_q  <= discard_q + wait_cnt - CW'(rsp_expected);
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
        if (rsp_drop) discard_q <= discard_q - CW'(1);
      end
      if (head_full) begin
        last_entry_q     <= head_entry;
        last_pc_plus_4_q <= head_entry.pc + XLEN'(4);
      end
    end
  end

  // An empty queue keeps showing the last instruction handed to decode.
  assign bus.id_valid     = head_full;
  assign bus.id_instr     = head_full ? head_entry.instr : last_entry_q.instr;
  assign bus.id_pc        = head_full ? head_entry.pc : last_entry_q.pc;
  assign bus.id_pc_plus_4 = head_full ? head_entry.pc + XLEN'(4) : last_pc_plus_4_q;

  rsp_has_request: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rsp_valid |-> rsp_expected);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue with an in-order variable-latency memory model.
module tb_if_prefetch_queue;
  import pipeline_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_prefetch_queue_if bus ();

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    pending[$];
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = RST_PC;
  int cyc = 0, last_due = 0, req_count = 0, delivered = 0;
  int n_err = 0, n_checks = 0, lat = 1;
  logic        drv_reset = 1'b1, drv_req_ready = 1'b0, drv_id_ready = 1'b0, drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + (a << 16);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then model memory and the expected stream.
  task automatic cycle();
    mem_req_t r;
    @(negedge clk);
    cyc++;
    reset              = drv_reset;
    bus.imem_req_ready = drv_req_ready;
    bus.id_ready       = drv_id_ready;
    bus.redirect_valid = drv_redirect;
    bus.redirect_pc    = drv_redirect_pc;
    if (drv_reset) begin
      pending.delete();
      last_due           = 0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else if (pending.size() > 0 && pending[0].due <= cyc) begin
      r                  = pending.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(r.addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #3;
    if (!reset && bus.imem_req_valid && bus.imem_req_ready) begin
      r.addr   = bus.imem_req_addr;
      r.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = r.due;
      pending.push_back(r);
      req_count++;
    end
    if (reset) begin
      exp_q.delete();
      gen_pc = RST_PC;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      gen_pc = drv_redirect_pc & ~32'h3;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 4;
    end
    drv_redirect = 1'b0;
  endtask

  task automatic do_reset();
    drv_reset = 1'b1;
    repeat (2) cycle();
    drv_reset = 1'b0;
  endtask

  // Monitor: every decode handshake pops one expected PC; a stalled head must stay put.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_pc, prev_instr, e;
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      if (hold_prev && bus.id_valid) begin
        check("stall_pc_stable", bus.id_pc, prev_pc);
        check("stall_instr_stable", bus.id_instr, prev_instr);
      end
      if (bus.id_valid && bus.id_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow: got pc %h expected no instruction", bus.id_pc);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", bus.id_pc, e);
          check("id_instr", bus.id_instr, mem_word(e));
          check("id_pc_plus_4", bus.id_pc_plus_4, e + 4);
          delivered++;
        end
      end
      hold_prev  = bus.id_valid && !bus.id_ready && !bus.redirect_valid;
      prev_pc    = bus.id_pc;
      prev_instr = bus.id_instr;
    end else begin
      hold_prev = 1'b0;
    end
  end

  int d0, r0, budget;

  initial begin
    reset              = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset state
    repeat (3) cycle();
    check("rst_req_valid", 32'(bus.imem_req_valid), 0);
    check("rst_id_valid", 32'(bus.id_valid), 0);
    check("rst_id_instr", bus.id_instr, 0);
    check("rst_id_pc", bus.id_pc, 0);
    check("rst_id_pc_plus_4", bus.id_pc_plus_4, 0);

    // Streaming with a 1-cycle memory
    drv_req_ready = 1'b1;
    drv_id_ready  = 1'b1;
    lat           = 1;
    drv_reset     = 1'b0;
    cycle();
    check("c0_req_valid", 32'(bus.imem_req_valid), 1);
    check("c0_req_addr", bus.imem_req_addr, RST_PC);
    cycle();
    check("c1_id_valid", 32'(bus.id_valid), 0);
    cycle();
    check("c2_id_valid", 32'(bus.id_valid), 1);
    d0 = delivered;
    repeat (16) cycle();
    check("throughput", 32'(delivered - d0), 16);

    // Decode stall fills the queue and stops issue
    drv_id_ready = 1'b0;
    do_reset();
    r0 = req_count;
    repeat (10) cycle();
    check("stall_req_count", 32'(req_count - r0), DEPTH);
    check("stall_req_valid", 32'(bus.imem_req_valid), 0);
    check("stall_head_valid", 32'(bus.id_valid), 1);
    check("stall_head_pc", bus.id_pc, 32'h0);
    drv_id_ready = 1'b1;
    d0 = delivered;
    repeat (12) cycle();
    check("stall_drain", 32'(delivered - d0), 12);

    // Redirect with two responses in flight on a 3-cycle memory
    drv_id_ready  = 1'b0;
    drv_req_ready = 1'b1;
    lat           = 3;
    do_reset();
    r0 = req_count;
    cycle();
    cycle();
    drv_req_ready   = 1'b0;
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'h103;
    cycle();
    check("redir_inflight", 32'(req_count - r0), 2);
    check("redir_no_issue", 32'(bus.imem_req_valid), 0);
    drv_req_ready = 1'b1;
    drv_id_ready  = 1'b1;
    cycle();
    check("redir_req_valid", 32'(bus.imem_req_valid), 1);
    check("redir_req_addr", bus.imem_req_addr, 32'h100);
    check("redir_squash_c3", 32'(bus.id_valid), 0);
    for (int i = 4; i <= 6; i++) begin
      cycle();
      check("redir_squash", 32'(bus.id_valid), 0);
    end
    cycle();
    check("redir_first_valid", 32'(bus.id_valid), 1);
    check("redir_first_pc", bus.id_pc, 32'h100);
    lat = 1;
    repeat (6) cycle();

    // Redirect together with a response and a decode handshake
    drv_id_ready  = 1'b1;
    drv_req_ready = 1'b1;
    lat           = 1;
    do_reset();
    repeat (6) cycle();
    drv_redirect    = 1'b1;
    drv_redirect_pc = 32'h200;
    cycle();
    check("coinc_setup_id", 32'(bus.id_valid), 1);
    check("coinc_setup_rsp", 32'(bus.imem_rsp_valid), 1);
    cycle();
    check("coinc_empty", 32'(bus.id_valid), 0);
    check("coinc_req_valid", 32'(bus.imem_req_valid), 1);
    check("coinc_req_addr", bus.imem_req_addr, 32'h200);
    repeat (6) cycle();

    // Random ready, latency, stalls and redirects
    d0     = delivered;
    budget = 0;
    while ((delivered - d0) < 2000 && budget < 40000) begin
      drv_req_ready = ($urandom_range(0, 3) != 0);
      drv_id_ready  = ($urandom_range(0, 3) != 0);
      lat           = $urandom_range(1, 4);
      if ($urandom_range(0, 39) == 0) begin
        drv_redirect    = 1'b1;
        drv_redirect_pc = $urandom_range(0, 32'h0000_FFFF);
      end
      cycle();
      budget++;
    end
    check("rand_delivered", 32'((delivered - d0) >= 2000), 1);

    // Reset mid-stream with three instructions buffered
    drv_id_ready  = 1'b0;
    drv_req_ready = 1'b1;
    lat           = 1;
    do_reset();
    repeat (3) cycle();
    drv_req_ready = 1'b0;
    repeat (3) cycle();
    check("mid_full_valid", 32'(bus.id_valid), 1);
    drv_reset = 1'b1;
    cycle();
    check("mid_rst_id_valid", 32'(bus.id_valid), 0);
    check("mid_rst_req_valid", 32'(bus.imem_req_valid), 0);
    cycle();
    drv_reset     = 1'b0;
    drv_req_ready = 1'b1;
    cycle();
    check("mid_rel_req_valid", 32'(bus.imem_req_valid), 1);
    check("mid_rel_req_addr", bus.imem_req_addr, RST_PC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
